// File: rtl/ccip_rd_engine.sv
// ccip_rd_engine: CCI-P c0 read initiator.
// Issues a contiguous run of line reads and forwards tagged responses.
module ccip_rd_engine #(
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [41:0]  base_addr,
  input  logic [15:0]  num_lines,
  output logic         busy,
  output logic         done,
  output logic         rd_req_valid,
  output logic [41:0]  rd_req_addr,
  output logic [15:0]  rd_req_mdata,
  input  logic         c0_almost_full,
  input  logic         rd_rsp_valid,
  input  logic [15:0]  rd_rsp_mdata,
  input  logic [511:0] rd_rsp_data,
  output logic         line_valid,
  output logic [15:0]  line_index,
  output logic [511:0] line_data
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] OUT_ONE = OW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [41:0]   r_base;
  logic [41:0]   w_base;
  logic [15:0]   r_num;
  logic [15:0]   w_num;
  logic [15:0]   r_idx;
  logic [15:0]   w_idx;
  logic [15:0]   w_idx_nxt;
  logic [15:0]   r_recv;
  logic [15:0]   w_recv;
  logic [15:0]   w_recv_nxt;
  logic [OW-1:0] r_out;
  logic [OW-1:0] w_out_nxt;

  logic w_start_acc;
  logic w_issue_ok;
  logic w_issue;
  logic w_rsp_acc;
  logic w_all_issued;
  logic w_drained;
  logic w_busy_nxt;
  logic w_done_nxt;

  // An accepted start feeds the fresh command straight into this
  // cycle's issue decision so the first request leaves at T+1.
  always_comb begin
    w_start_acc = (r_state == S_IDLE) && start;
    w_base      = w_start_acc ? base_addr : r_base;
    w_num       = w_start_acc ? num_lines : r_num;
    w_idx       = w_start_acc ? 16'd0 : r_idx;
    w_recv      = w_start_acc ? 16'd0 : r_recv;

    w_issue_ok = (r_state == S_ISSUE) ||
                 (w_start_acc && (num_lines != 16'd0));
    w_issue    = w_issue_ok && !c0_almost_full &&
                 (r_out < OUT_MAX) && (w_idx < w_num);

    w_rsp_acc = rd_rsp_valid && (r_out != '0) &&
                ((r_state == S_ISSUE) || (r_state == S_DRAIN));

    w_idx_nxt  = w_issue ? w_idx + 16'd1 : w_idx;
    w_recv_nxt = w_rsp_acc ? w_recv + 16'd1 : w_recv;

    w_out_nxt = r_out;
    if (w_issue && !w_rsp_acc)
      w_out_nxt = r_out + OUT_ONE;
    else if (!w_issue && w_rsp_acc)
      w_out_nxt = r_out - OUT_ONE;

    w_all_issued = (w_idx_nxt == w_num);
    w_drained    = (w_out_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_state_nxt = (num_lines == 16'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_all_issued)
          w_state_nxt = w_drained ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drained && (w_recv_nxt == r_num))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_num  <= '0;
      r_idx  <= '0;
      r_recv <= '0;
      r_out  <= '0;
    end else begin
      r_base <= w_base;
      r_num  <= w_num;
      r_idx  <= w_idx_nxt;
      r_recv <= w_recv_nxt;
      r_out  <= w_out_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      line_valid   <= 1'b0;
      line_index   <= '0;
      line_data    <= '0;
    end else begin
      busy         <= w_busy_nxt;
      done         <= w_done_nxt;
      rd_req_valid <= w_issue;
      line_valid   <= w_rsp_acc;
      if (w_issue) begin
        rd_req_addr  <= w_base + {26'd0, w_idx};
        rd_req_mdata <= w_idx;
      end
      if (w_rsp_acc) begin
        line_index <= rd_rsp_mdata;
        line_data  <= rd_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_ccip_rd_engine.sv
// tb_ccip_rd_engine: randomized bench for ccip_rd_engine.
// A cycle model of the read protocol predicts every output.
module tb_ccip_rd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [41:0]  base_addr = '0;
  logic [15:0]  num_lines = '0;
  logic         c0_almost_full = 1'b0;
  logic         rd_rsp_valid = 1'b0;
  logic [15:0]  rd_rsp_mdata = '0;
  logic [511:0] rd_rsp_data = '0;

  logic         busy, done, rd_req_valid, line_valid;
  logic [41:0]  rd_req_addr;
  logic [15:0]  rd_req_mdata, line_index;
  logic [511:0] line_data;

  logic         b_busy, b_done, b_rd_req_valid, b_line_valid;
  logic [41:0]  b_rd_req_addr;
  logic [15:0]  b_rd_req_mdata, b_line_index;
  logic [511:0] b_line_data;

  ccip_rd_engine #(.MAX_OUTSTANDING(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_mdata(rd_req_mdata), .c0_almost_full(c0_almost_full),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data), .line_valid(line_valid),
    .line_index(line_index), .line_data(line_data)
  );

  ccip_rd_engine #(.MAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .num_lines(num_lines),
    .busy(b_busy), .done(b_done),
    .rd_req_valid(b_rd_req_valid), .rd_req_addr(b_rd_req_addr),
    .rd_req_mdata(b_rd_req_mdata), .c0_almost_full(c0_almost_full),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data), .line_valid(b_line_valid),
    .line_index(b_line_index), .line_data(b_line_data)
  );

  typedef struct {
    int           ph;
    logic [41:0]  base;
    int           n;
    int           nxt;
    int           infl;
    logic         busy;
    logic         done;
    logic         rqv;
    logic [41:0]  ra;
    logic [15:0]  rm;
    logic         lv;
    logic [15:0]  li;
    logic [511:0] ld;
  } mst_t;

  mst_t m1, m2;
  int errs = 0;
  int checks = 0;
  int pend[$];

  function automatic mst_t mzero();
    mst_t z;
    z.ph = 0; z.base = '0; z.n = 0; z.nxt = 0; z.infl = 0;
    z.busy = 0; z.done = 0; z.rqv = 0; z.ra = '0; z.rm = '0;
    z.lv = 0; z.li = '0; z.ld = '0;
    return z;
  endfunction

  // phases: 0 idle, 1 issuing, 2 draining, 3 done
  function automatic mst_t mstep(mst_t s, int maxo);
    mst_t o;
    bit take, go, issuing;
    o = s;
    take = rd_rsp_valid && (s.ph == 1 || s.ph == 2) && s.infl > 0;
    if (s.ph == 0 && start) begin
      o.base = base_addr;
      o.n = int'(num_lines);
      o.nxt = 0;
    end
    issuing = (s.ph == 1) || (s.ph == 0 && start && num_lines != 0);
    go = issuing && !c0_almost_full && s.infl < maxo && o.nxt < o.n;
    o.rqv = go;
    o.lv = take;
    if (go) begin
      o.ra = o.base + 42'(o.nxt);
      o.rm = 16'(o.nxt);
      o.nxt = o.nxt + 1;
    end
    if (take) begin
      o.li = rd_rsp_mdata;
      o.ld = rd_rsp_data;
    end
    o.infl = s.infl + (go ? 1 : 0) - (take ? 1 : 0);
    case (s.ph)
      0: if (start) o.ph = (num_lines == 0) ? 3 : 1;
      1: if (o.nxt == o.n) o.ph = (o.infl == 0) ? 3 : 2;
      2: if (o.infl == 0) o.ph = 3;
      default: o.ph = 0;
    endcase
    o.busy = (o.ph != 0);
    o.done = (o.ph == 3);
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= mzero();
      m2 <= mzero();
    end else begin
      m1 <= mstep(m1, 64);
      m2 <= mstep(m2, 2);
    end
  end

  logic [589:0] v1, e1, v2, e2;
  assign v1 = {busy, done, rd_req_valid, rd_req_addr, rd_req_mdata,
               line_valid, line_index, line_data};
  assign e1 = {m1.busy, m1.done, m1.rqv, m1.ra, m1.rm,
               m1.lv, m1.li, m1.ld};
  assign v2 = {b_busy, b_done, b_rd_req_valid, b_rd_req_addr,
               b_rd_req_mdata, b_line_valid, b_line_index, b_line_data};
  assign e2 = {m2.busy, m2.done, m2.rqv, m2.ra, m2.rm,
               m2.lv, m2.li, m2.ld};

  task automatic clr_in();
    start = 0;
    c0_almost_full = 0;
    rd_rsp_valid = 0;
    rd_rsp_mdata = '0;
    rd_rsp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clr_in();
    pend.delete();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic kick(logic [41:0] b, logic [15:0] n);
    start = 1;
    base_addr = b;
    num_lines = n;
  endtask

  task automatic rsp_step(int pct);
    rd_rsp_valid = 0;
    if (pend.size() > 0 && $urandom_range(99) < pct) begin
      rd_rsp_valid = 1;
      rd_rsp_mdata = 16'(pend.pop_front());
      rd_rsp_data = {16{$urandom()}};
    end
    if (m1.rqv) pend.push_back(int'(m1.rm));
  endtask

  task automatic test_reset();
    #1;
    rst = 1;
    clr_in();
    repeat (2) @(negedge clk);
    checks++;
    if (v1 !== '0) begin
      errs++; $display("FAIL reset_vals got=%h exp=0", v1);
    end
    checks++;
    if (v2 !== '0) begin
      errs++; $display("FAIL reset_vals2 got=%h exp=0", v2);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (v1 !== e1 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_idle got=%h exp=%h", v1, e1);
    end
  endtask

  task automatic test_basic();
    do_reset();
    kick(42'h1000, 16'd4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v1 !== e1) begin
        errs++; $display("FAIL basic_model i=%0d got=%h exp=%h", i, v1, e1);
      end
      if (i <= 4) begin
        checks++;
        if (rd_req_valid !== 1'b1 || rd_req_addr !== 42'h1000 + 42'(i-1) ||
            rd_req_mdata !== 16'(i-1)) begin
          errs++;
          $display("FAIL basic_req i=%0d got=%b/%h/%0d exp=1/%h/%0d",
                   i, rd_req_valid, rd_req_addr, rd_req_mdata,
                   42'h1000 + 42'(i-1), i-1);
        end
      end
      if (i >= 3 && i <= 6) begin
        checks++;
        if (line_valid !== 1'b1 || line_index !== 16'(i-3) ||
            line_data !== 512'(i-3)) begin
          errs++;
          $display("FAIL basic_line i=%0d got=%b/%0d exp=1/%0d",
                   i, line_valid, line_index, i-3);
        end
      end
      if (i == 6 || i == 7) begin
        checks++;
        if (done !== (i == 6) || busy !== (i == 6)) begin
          errs++;
          $display("FAIL basic_done i=%0d got=%b/%b exp=%b/%b",
                   i, done, busy, i == 6, i == 6);
        end
      end
      rd_rsp_valid = (i >= 2 && i <= 5);
      rd_rsp_mdata = 16'(i-2);
      rd_rsp_data = 512'(i-2);
    end
    clr_in();
  endtask

  task automatic test_ooo();
    int ord[4] = '{2, 0, 3, 1};
    logic [511:0] d[4];
    logic [41:0] b;
    b = 42'({$urandom(), $urandom()});
    for (int k = 0; k < 4; k++) d[k] = {16{$urandom()}};
    do_reset();
    kick(b, 16'd4);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v1 !== e1) begin
        errs++; $display("FAIL ooo_model i=%0d got=%h exp=%h", i, v1, e1);
      end
      if (i >= 7 && i <= 10) begin
        checks++;
        if (line_valid !== 1'b1 || line_index !== 16'(ord[i-7]) ||
            line_data !== d[ord[i-7]]) begin
          errs++;
          $display("FAIL ooo_line i=%0d got=%b/%0d exp=1/%0d",
                   i, line_valid, line_index, ord[i-7]);
        end
      end
      if (i == 10 || i == 11) begin
        checks++;
        if (done !== (i == 10) || busy !== (i == 10)) begin
          errs++;
          $display("FAIL ooo_done i=%0d got=%b/%b", i, done, busy);
        end
      end
      rd_rsp_valid = (i >= 6 && i <= 9);
      rd_rsp_mdata = (i >= 6 && i <= 9) ? 16'(ord[i-6]) : 16'd0;
      rd_rsp_data = (i >= 6 && i <= 9) ? d[ord[i-6]] : '0;
    end
    clr_in();
  endtask

  task automatic test_credit();
    int nreq, nd;
    int tags[$];
    nreq = 0;
    nd = 0;
    do_reset();
    kick(42'h20000, 16'd8);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v2 !== e2) begin
        errs++; $display("FAIL credit_model i=%0d got=%h exp=%h", i, v2, e2);
      end
      if (b_rd_req_valid === 1'b1) begin
        nreq++;
        tags.push_back(int'(b_rd_req_mdata));
      end
      if (b_done === 1'b1) nd++;
      if (i == 6 || i == 8) begin
        checks++;
        if (nreq != 2) begin
          errs++; $display("FAIL credit_hold i=%0d got=%0d exp=2", i, nreq);
        end
      end
      if (i == 9 || i == 12 || i == 15 || i == 18) begin
        checks++;
        if (nreq != 3 + (i - 9) / 3) begin
          errs++;
          $display("FAIL credit_release i=%0d got=%0d exp=%0d",
                   i, nreq, 3 + (i - 9) / 3);
        end
      end
      rd_rsp_valid = 0;
      if (pend.size() > 0 && i >= 7 && ((i - 7) % 3 == 0 || i >= 19)) begin
        rd_rsp_valid = 1;
        rd_rsp_mdata = 16'(pend.pop_front());
        rd_rsp_data = {16{$urandom()}};
      end
      if (m2.rqv) pend.push_back(int'(m2.rm));
    end
    checks++;
    if (nreq != 8 || nd != 1) begin
      errs++; $display("FAIL credit_total got=%0d/%0d exp=8/1", nreq, nd);
    end
    for (int k = 0; k < tags.size(); k++) begin
      checks++;
      if (tags[k] != k) begin
        errs++; $display("FAIL credit_tag k=%0d got=%0d exp=%0d", k, tags[k], k);
      end
    end
    clr_in();
  endtask

  task automatic test_af();
    int tags[$];
    int nd;
    logic [41:0] b;
    nd = 0;
    b = 42'({$urandom(), $urandom()});
    do_reset();
    kick(b, 16'd12);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v1 !== e1) begin
        errs++; $display("FAIL af_model i=%0d got=%h exp=%h", i, v1, e1);
      end
      if (rd_req_valid === 1'b1) tags.push_back(int'(rd_req_mdata));
      if (done === 1'b1) nd++;
      if (i >= 5 && i <= 9) begin
        checks++;
        if (rd_req_valid !== 1'b0) begin
          errs++; $display("FAIL af_stall i=%0d got=%b exp=0", i, rd_req_valid);
        end
      end
      if (i == 10) begin
        checks++;
        if (rd_req_valid !== 1'b1 || rd_req_mdata !== 16'd4) begin
          errs++;
          $display("FAIL af_resume got=%b/%0d exp=1/4", rd_req_valid, rd_req_mdata);
        end
      end
      c0_almost_full = (i >= 4 && i <= 8);
      rsp_step(70);
    end
    checks++;
    if (tags.size() != 12 || nd != 1) begin
      errs++; $display("FAIL af_total got=%0d/%0d exp=12/1", tags.size(), nd);
    end
    for (int k = 0; k < tags.size(); k++) begin
      checks++;
      if (tags[k] != k) begin
        errs++; $display("FAIL af_tag k=%0d got=%0d exp=%0d", k, tags[k], k);
      end
    end
    clr_in();
    pend.delete();
    kick(42'h3FF_FFFF_FFFF, 16'd2);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v1 !== e1) begin
        errs++; $display("FAIL wrap_model i=%0d got=%h exp=%h", i, v1, e1);
      end
      if (i <= 2) begin
        checks++;
        if (rd_req_valid !== 1'b1 ||
            rd_req_addr !== ((i == 1) ? 42'h3FF_FFFF_FFFF : 42'h0)) begin
          errs++;
          $display("FAIL wrap_addr i=%0d got=%b/%h", i, rd_req_valid, rd_req_addr);
        end
      end
      rsp_step(70);
    end
    clr_in();
  endtask

  task automatic test_zero();
    logic [41:0] b;
    int addrs[$];
    int nd;
    logic [41:0] got[$];
    nd = 0;
    b = 42'({$urandom(), $urandom()});
    do_reset();
    kick(b, 16'd0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (done !== (i == 1) || busy !== (i == 1) || rd_req_valid !== 1'b0 ||
          v1 !== e1) begin
        errs++;
        $display("FAIL zero_len i=%0d got=%b/%b/%b", i, done, busy, rd_req_valid);
      end
    end
    kick(b, 16'd5);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 2);
      base_addr = (i == 2) ? ~b : b;
      num_lines = (i == 2) ? 16'd9 : 16'd5;
      checks++;
      if (v1 !== e1) begin
        errs++; $display("FAIL ignore_model i=%0d got=%h exp=%h", i, v1, e1);
      end
      if (rd_req_valid === 1'b1) begin
        got.push_back(rd_req_addr);
        addrs.push_back(int'(rd_req_mdata));
      end
      if (done === 1'b1) nd++;
      rsp_step(60);
    end
    checks++;
    if (got.size() != 5 || nd != 1) begin
      errs++; $display("FAIL ignore_total got=%0d/%0d exp=5/1", got.size(), nd);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== b + 42'(k) || addrs[k] != k) begin
        errs++;
        $display("FAIL ignore_addr k=%0d got=%h/%0d exp=%h/%0d",
                 k, got[k], addrs[k], b + 42'(k), k);
      end
    end
    clr_in();
  endtask

  task automatic test_reset_mid();
    logic [41:0] b;
    int nd;
    nd = 0;
    b = 42'({$urandom(), $urandom()});
    do_reset();
    kick(b, 16'd8);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v1 !== e1 || rd_req_valid !== 1'b1) begin
        errs++; $display("FAIL rmid_pre i=%0d got=%h exp=%h", i, v1, e1);
      end
    end
    rst = 1;
    #1;
    checks++;
    if (v1 !== '0) begin
      errs++; $display("FAIL rmid_reset got=%h exp=0", v1);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      rd_rsp_valid = (i < 3);
      rd_rsp_mdata = 16'(i);
      rd_rsp_data = {16{$urandom()}};
      @(negedge clk);
      checks++;
      if (v1 !== '0 || v1 !== e1) begin
        errs++; $display("FAIL rmid_drop i=%0d got=%h exp=0", i, v1);
      end
    end
    clr_in();
    pend.delete();
    kick(b, 16'd3);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (v1 !== e1) begin
        errs++; $display("FAIL rmid_rerun i=%0d got=%h exp=%h", i, v1, e1);
      end
      if (i == 1) begin
        checks++;
        if (rd_req_valid !== 1'b1 || rd_req_mdata !== 16'd0 || rd_req_addr !== b) begin
          errs++;
          $display("FAIL rmid_first got=%b/%0d/%h exp=1/0/%h",
                   rd_req_valid, rd_req_mdata, rd_req_addr, b);
        end
      end
      if (done === 1'b1) nd++;
      rsp_step(60);
    end
    checks++;
    if (nd != 1) begin
      errs++; $display("FAIL rmid_done got=%0d exp=1", nd);
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ooo();
    test_credit();
    test_af();
    test_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
